// File: rtl/prewitt_raster_sink_pkg.sv
// Shared definitions for the Prewitt raster sink: FSM states and default frame geometry.
package prewitt_raster_sink_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  localparam int DEF_ROWS = 500;
  localparam int DEF_COLS = 500;
  localparam int DEF_IN_W = 16;
  localparam int DEF_PIX_W = 8;
endpackage

// File: rtl/prewitt_raster_sink_clamp.sv
// Signed IN_W -> unsigned PIX_W saturating clamp; shared with the 3x3 core.
module sat_clamp_u8 #(
  parameter int IN_W  = 16,
  parameter int PIX_W = 8
) (
  input  logic signed [IN_W-1:0]  din,
  output logic        [PIX_W-1:0] dout
);
  // Any set magnitude bit above PIX_W means the value exceeds the ceiling.
  always_comb begin
    dout = din[PIX_W-1:0];
    if (din[IN_W-1])              dout = '0;
    else if (|din[IN_W-2:PIX_W])  dout = '1;
  end
endmodule

// File: rtl/prewitt_raster_sink.sv
// Rebuilds a ROWS x COLS raster from interior edge samples, inserting zero borders.
module prewitt_raster_sink
  import prewitt_raster_sink_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int IN_W  = DEF_IN_W,
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIX_W-1:0]       out_data,
  output logic                   out_eol,
  output logic                   out_eof,
  output logic                   busy,
  output logic                   frame_done
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);

  state_t            state, state_nxt;
  logic [RW-1:0]     row;
  logic [CW-1:0]     col;
  logic [PIX_W-1:0]  clamped;
  logic              border, last_pos, can_load, load, eof_fire;

  sat_clamp_u8 #(.IN_W(IN_W), .PIX_W(PIX_W)) u_clamp (.din(in_data), .dout(clamped));

  assign border   = (row == '0) || (row == R_LAST) || (col == '0) || (col == C_LAST);
  assign last_pos = (row == R_LAST) && (col == C_LAST);
  assign can_load = (state == ST_STREAM) && (!out_valid || out_ready);
  assign load     = can_load && (border || in_valid);
  assign in_ready = can_load && !border;
  assign eof_fire = (state == ST_DRAIN) && out_valid && out_ready && out_eof;
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_STREAM;
      ST_STREAM: if (load && last_pos) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (eof_fire) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      row        <= '0;
      col        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_eol    <= 1'b0;
      out_eof    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= eof_fire;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= border ? '0 : clamped;
        out_eol   <= (col == C_LAST);
        out_eof   <= last_pos;
        // Counters return to (0,0) after the last position so the next frame starts clean.
        if (col == C_LAST) begin
          col <= '0;
          row <= last_pos ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
